// File: rtl/add_share_arbiter.sv
// Round-robin scheduler sharing one registered adder between NUM_REQ requesters.
// Grants are combinational; a tag pipeline matches adder results to requester ids.
module add_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADD_LATENCY = 1,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          add_ebl,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_out,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int unsigned PIPE_IDW = ADD_LATENCY * ID_W;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       grant_id;
    logic                  found;
    logic                  grant;
    int unsigned           cand;

    logic [ADD_LATENCY-1:0] pipe_vld;
    logic [PIPE_IDW-1:0]    pipe_id;
    logic [ADD_LATENCY:0]   pipe_vld_ext;
    logic [PIPE_IDW+ID_W-1:0] pipe_id_ext;
    logic                   last_vld;
    logic [ID_W-1:0]        last_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + 32'(k)) % NUM_REQ;
            if (!found && req_valid[ID_W'(cand)]) begin
                found    = 1'b1;
                grant_id = ID_W'(cand);
            end
        end
    end

    assign grant = arb_en & found;

    always_comb begin
        req_ready = '0;
        add_ebl   = 1'b0;
        add_a     = '0;
        add_b     = '0;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
            add_ebl             = 1'b1;
            add_a               = a_arr[grant_id];
            add_b               = b_arr[grant_id];
        end
    end

    // Shift registers are widened by one stage so the new entry concatenates in.
    assign pipe_vld_ext = {pipe_vld, grant};
    assign pipe_id_ext  = {pipe_id, grant_id};
    assign last_vld     = pipe_vld[ADD_LATENCY-1];
    assign last_id      = pipe_id[PIPE_IDW-1 -: ID_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            pipe_vld  <= '0;
            pipe_id   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            if (grant) begin
                ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            pipe_vld  <= pipe_vld_ext[ADD_LATENCY-1:0];
            pipe_id   <= pipe_id_ext[PIPE_IDW-1:0];
            rsp_valid <= last_vld;
            if (last_vld) begin
                rsp_id   <= last_id;
                rsp_data <= add_out;
            end
            busy <= grant | (|pipe_vld);
        end
    end

endmodule
